// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared word layout, scrub state encoding and SECDED helpers
// Word layout: {parity[6:0], data[26:0]}. parity[5:0] are Hamming check bits
// over codeword positions 1..33 (check bits at the power-of-two positions),
// parity[6] is the overall parity of data and check bits.
package ecc_pkg;
  localparam int ECC_DATA_W   = 27;
  localparam int ECC_PARITY_W = 7;
  localparam int ECC_WORD_W   = ECC_DATA_W + ECC_PARITY_W;
  localparam int DATA_LSB     = 0;
  localparam int DATA_MSB     = 26;
  localparam int PAR_LSB      = 27;
  localparam int PAR_MSB      = 33;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_RD      = 3'd2,
    S_RD_WAIT = 3'd3,
    S_CHECK   = 3'd4,
    S_WR      = 3'd5,
    S_NEXT    = 3'd6
  } scrub_state_t;

  // Codeword position of data bit idx: the idx-th non-power-of-two position.
  function automatic logic [5:0] data_pos(input int idx);
    logic [5:0] pos;
    int cnt;
    pos = '0;
    cnt = 0;
    for (int p = 1; p < 34; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = 6'(p);
        cnt++;
      end
    end
    return pos;
  endfunction

  // Each check bit j covers the data bits whose position has bit j set.
  function automatic logic [5:0] hamming_chk(input logic [ECC_DATA_W-1:0] d);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < ECC_DATA_W; i++) c = c ^ ({6{d[i]}} & data_pos(i));
    return c;
  endfunction

  function automatic logic [ECC_PARITY_W-1:0] ecc_encode(input logic [ECC_DATA_W-1:0] d);
    logic [5:0] c;
    c = hamming_chk(d);
    return {(^d) ^ (^c), c};
  endfunction
endpackage

// File: rtl/ecc_27_cal.sv
// rtl/ecc_27_cal.sv - SECDED check/correct for a 27-bit data, 7-bit parity word
// Ports: bypass (pass word through, no flags), parity_in/data_in (stored word),
// parity_out/data_out (corrected data with regenerated parity), sbit_err,
// dbit_err, err_mask (data bit flipped by the correction; 0 for parity-only errors).
module ecc_27_cal
  import ecc_pkg::*;
(
  input  logic                    bypass,
  input  logic [ECC_PARITY_W-1:0] parity_in,
  input  logic [ECC_DATA_W-1:0]   data_in,
  output logic [ECC_PARITY_W-1:0] parity_out,
  output logic [ECC_DATA_W-1:0]   data_out,
  output logic                    sbit_err,
  output logic                    dbit_err,
  output logic [ECC_DATA_W-1:0]   err_mask
);
  logic [5:0]            syn;
  logic                  ovr;
  logic                  chk_pos;
  logic [ECC_DATA_W-1:0] mask;
  logic [ECC_DATA_W-1:0] fixed;

  always_comb begin
    syn  = hamming_chk(data_in) ^ parity_in[5:0];
    ovr  = ^{parity_in, data_in};
    mask = '0;
    for (int i = 0; i < ECC_DATA_W; i++) begin
      if (syn == data_pos(i)) mask[i] = 1'b1;
    end
    // Syndrome 0 or a power of two points at a parity bit, not a data bit.
    chk_pos = ((syn & (syn - 6'd1)) == 6'd0);
    fixed   = data_in ^ mask;
  end

  // Odd overall parity is a single flip unless the syndrome names no real
  // position (34..63); even parity with a nonzero syndrome is a double flip.
  assign sbit_err   = !bypass && ovr && ((|mask) || chk_pos);
  assign dbit_err   = !bypass && (syn != 6'd0) && (!ovr || (!chk_pos && !(|mask)));
  assign err_mask   = bypass ? '0 : mask;
  assign data_out   = bypass ? data_in : fixed;
  assign parity_out = bypass ? parity_in : ecc_encode(fixed);
endmodule

// File: rtl/ecc_scrub_ctrl.sv
// rtl/ecc_scrub_ctrl.sv - background ECC scrubber sharing the RAM port with functional logic
// Ports: scrub_en/scrub_intv (enable, idle cycles between words), func_busy/
// func_we/func_waddr (functional port owner and its writes), mem_req/mem_we/
// mem_addr/mem_wdata/mem_rdata (RAM port, read data one cycle after request),
// sbit_cnt/dbit_cnt (saturating error counters, cleared by cnt_clr),
// dbit_addr/dbit_irq (last uncorrectable address, 1-cycle pulse), pass_done.
module ecc_scrub_ctrl
  import ecc_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 27,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16,
  parameter int INTV_WIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             scrub_en,
  input  logic [INTV_WIDTH-1:0]            scrub_intv,
  input  logic                             func_busy,
  input  logic                             func_we,
  input  logic [ADDR_WIDTH-1:0]            func_waddr,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH+PARITY_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH+PARITY_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]             sbit_cnt,
  output logic [CNT_WIDTH-1:0]             dbit_cnt,
  output logic [ADDR_WIDTH-1:0]            dbit_addr,
  output logic                             dbit_irq,
  output logic                             pass_done,
  input  logic                             cnt_clr
);
  scrub_state_t            state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [INTV_WIDTH-1:0]   intv_cnt;
  logic [ECC_WORD_W-1:0]   rword;
  logic [ECC_WORD_W-1:0]   wdata;
  logic                    abort;
  logic                    hazard;
  logic [ECC_PARITY_W-1:0] ecc_parity;
  logic [ECC_DATA_W-1:0]   ecc_data;
  logic [ECC_DATA_W-1:0]   ecc_mask;
  logic                    ecc_sbit;
  logic                    ecc_dbit;
  logic                    sbit_inc;
  logic                    dbit_inc;

  ecc_27_cal u_ecc (
    .bypass     (1'b0),
    .parity_in  (rword[PAR_MSB:PAR_LSB]),
    .data_in    (rword[DATA_MSB:DATA_LSB]),
    .parity_out (ecc_parity),
    .data_out   (ecc_data),
    .sbit_err   (ecc_sbit),
    .dbit_err   (ecc_dbit),
    .err_mask   (ecc_mask)
  );

  // A functional write to the word in flight makes our corrected copy stale.
  assign hazard    = func_we && (func_waddr == addr);
  assign mem_req   = !func_busy && ((state == S_RD) || (state == S_WR && !abort && !hazard));
  assign mem_we    = (state == S_WR);
  assign mem_addr  = addr;
  assign mem_wdata = wdata;
  assign sbit_inc  = (state == S_CHECK) && ecc_sbit && (|ecc_mask);
  assign dbit_inc  = (state == S_CHECK) && ecc_dbit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      intv_cnt  <= '0;
      rword     <= '0;
      wdata     <= '0;
      abort     <= 1'b0;
      pass_done <= 1'b0;
    end else begin
      pass_done <= 1'b0;
      if (hazard && (state == S_RD_WAIT || state == S_CHECK || state == S_WR)) abort <= 1'b1;
      case (state)
        S_IDLE: begin
          if (scrub_en) begin
            intv_cnt <= scrub_intv;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (intv_cnt == '0) state <= S_RD;
          else intv_cnt <= intv_cnt - INTV_WIDTH'(1);
        end
        S_RD: begin
          if (!func_busy) begin
            abort <= hazard;
            state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          rword <= mem_rdata;
          state <= S_CHECK;
        end
        S_CHECK: begin
          wdata <= {ecc_parity, ecc_data};
          if (ecc_sbit && !ecc_dbit) state <= S_WR;
          else state <= S_NEXT;
        end
        S_WR: begin
          if (abort || hazard || !func_busy) state <= S_NEXT;
        end
        S_NEXT: begin
          addr <= addr + ADDR_WIDTH'(1);
          if (addr == '1) pass_done <= 1'b1;
          if (scrub_en) begin
            intv_cnt <= scrub_intv;
            state    <= S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt  <= '0;
      dbit_cnt  <= '0;
      dbit_addr <= '0;
      dbit_irq  <= 1'b0;
    end else begin
      dbit_irq <= 1'b0;
      if (cnt_clr) sbit_cnt <= '0;
      else if (sbit_inc && sbit_cnt != '1) sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
      if (cnt_clr) dbit_cnt <= '0;
      else if (dbit_inc && dbit_cnt != '1) dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
      if (dbit_inc) begin
        dbit_addr <= addr;
        dbit_irq  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb/tb_ecc_scrub_ctrl.sv - self-checking bench for ecc_scrub_ctrl
module tb_ecc_scrub_ctrl;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = 5;
  localparam int IW    = 16;
  localparam int WW    = 34;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scrub_en = 1'b0;
  logic [IW-1:0] scrub_intv = '0;
  logic          func_busy = 1'b0;
  logic          func_we = 1'b0;
  logic [AW-1:0] func_waddr = '0;
  logic [WW-1:0] func_wdata = '0;
  logic          cnt_clr = 1'b0;
  logic          mem_req, mem_we, dbit_irq, pass_done;
  logic [AW-1:0] mem_addr, dbit_addr;
  logic [WW-1:0] mem_wdata;
  logic [WW-1:0] mem_rdata = '0;
  logic [CW-1:0] sbit_cnt, dbit_cnt;

  always #5 clk = ~clk;

  ecc_scrub_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .INTV_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .scrub_intv(scrub_intv),
    .func_busy(func_busy), .func_we(func_we), .func_waddr(func_waddr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .dbit_addr(dbit_addr), .dbit_irq(dbit_irq), .pass_done(pass_done), .cnt_clr(cnt_clr)
  );

  // RAM model plus transaction monitor
  logic [WW-1:0] ram [DEPTH];
  logic [WW-1:0] img [DEPTH];
  logic          ram_load = 1'b0;
  logic          mon_clr = 1'b1;
  int            n_rd, n_wr, n_irq, n_pass, n_viol;
  logic [AW-1:0] last_wr_addr;

  always @(posedge clk) begin
    if (mon_clr) begin
      n_rd = 0; n_wr = 0; n_irq = 0; n_pass = 0; n_viol = 0;
    end else begin
      if (mem_req && func_busy) n_viol++;
      if (mem_req && !mem_we) n_rd++;
      if (mem_req && mem_we) begin n_wr++; last_wr_addr = mem_addr; end
      if (dbit_irq) n_irq++;
      if (pass_done) n_pass++;
    end
    if (ram_load) ram <= img;
    else begin
      if (func_we) ram[func_waddr] <= func_wdata;
      if (mem_req && mem_we) ram[mem_addr] <= mem_wdata;
    end
    if (mem_req && !mem_we) mem_rdata <= ram[mem_addr];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder: place data in the non-power-of-two positions 1..33,
  // check bit j = XOR of positions with bit j set, plus overall parity.
  function automatic logic [WW-1:0] enc(input logic [26:0] d);
    logic [33:1] cw;
    logic [5:0]  c;
    int k;
    cw = '0; k = 0; c = '0;
    for (int p = 1; p <= 33; p++) if ((p & (p - 1)) != 0) begin cw[p] = d[k]; k++; end
    for (int p = 1; p <= 33; p++)
      for (int j = 0; j < 6; j++) if (((p >> j) & 1) == 1) c[j] = c[j] ^ cw[p];
    return {(^d) ^ (^c), c, d};
  endfunction

  // Brute-force nearest codeword: 0 clean, 1 one flip (bitpos), 2 uncorrectable
  function automatic int classify(input logic [WW-1:0] w, output int bitpos);
    logic [WW-1:0] t;
    bitpos = -1;
    if (enc(w[26:0]) == w) return 0;
    for (int b = 0; b < WW; b++) begin
      t = w; t[b] = ~t[b];
      if (enc(t[26:0]) == t) begin bitpos = b; return 1; end
    end
    return 2;
  endfunction

  task automatic clean_image();
    logic [31:0] r;
    for (int a = 0; a < DEPTH; a++) begin r = $urandom; img[a] = enc(r[26:0]); end
  endtask

  task automatic prep(input bit clr_cnt);
    @(negedge clk);
    ram_load = 1'b1; mon_clr = 1'b1; cnt_clr = clr_cnt;
    @(negedge clk);
    ram_load = 1'b0; mon_clr = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic run_pass(input int intv);
    int t;
    scrub_intv = IW'(intv);
    scrub_en = 1'b1;
    t = 0;
    while (n_rd < DEPTH && t < 3000) begin @(negedge clk); t++; end
    scrub_en = 1'b0;
    while (n_pass < 1 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin
      n_vec++; n_bad++;
      $display("FAIL pass_timeout: reads %0d pass %0d", n_rd, n_pass);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_read(input logic [AW-1:0] a, output int cyc);
    cyc = 0;
    while (!(mem_req && !mem_we && mem_addr == a) && cyc < 2000) begin @(negedge clk); cyc++; end
    if (cyc >= 2000) begin
      n_vec++; n_bad++;
      $display("FAIL read_timeout: addr %0d never read", a);
    end
  endtask

  typedef struct {
    int addr; int f0; int f1; int exp_wr; int exp_sb; int exp_db;
  } vec_t;
  vec_t tbl [8];

  initial begin
    logic [WW-1:0] clean_w, bad_w, fdat;
    logic [31:0]   r;
    int t, busy_req, bp, kind, b0, b1;
    int e_sb, e_db, e_wr, last_db, ram_err;

    tbl[0] = '{0,  -1, -1, 0, 0, 0};
    tbl[1] = '{5,   3, -1, 1, 1, 0};
    tbl[2] = '{9,   0,  1, 0, 0, 1};
    tbl[3] = '{0,  33, -1, 1, 0, 0};
    tbl[4] = '{63, 27, -1, 1, 0, 0};
    tbl[5] = '{40, 26, -1, 1, 1, 0};
    tbl[6] = '{20, 26, 30, 0, 0, 1};
    tbl[7] = '{33, 31, 32, 0, 0, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, sbit_cnt, dbit_cnt,
                          dbit_addr, dbit_irq, pass_done}, 64'd0);
    rst_n = 1'b1;
    mon_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_req", {mem_req, mem_addr}, 64'd0);

    // Table-driven single-error scenarios, one full pass each
    for (int v = 0; v < 8; v++) begin
      clean_image();
      clean_w = img[tbl[v].addr];
      bad_w = clean_w;
      if (tbl[v].f0 >= 0) bad_w[tbl[v].f0] = ~bad_w[tbl[v].f0];
      if (tbl[v].f1 >= 0) bad_w[tbl[v].f1] = ~bad_w[tbl[v].f1];
      img[tbl[v].addr] = bad_w;
      prep(1'b1);
      run_pass(0);
      chk($sformatf("tbl%0d_reads", v), n_rd, DEPTH);
      chk($sformatf("tbl%0d_writes", v), n_wr, tbl[v].exp_wr);
      chk($sformatf("tbl%0d_sbit_cnt", v), sbit_cnt, tbl[v].exp_sb);
      chk($sformatf("tbl%0d_dbit_cnt", v), dbit_cnt, tbl[v].exp_db);
      chk($sformatf("tbl%0d_irq_cycles", v), n_irq, tbl[v].exp_db);
      chk($sformatf("tbl%0d_pass_done", v), n_pass, 1);
      chk($sformatf("tbl%0d_ptr_wrap", v), mem_addr, 0);
      chk($sformatf("tbl%0d_port_viol", v), n_viol, 0);
      chk($sformatf("tbl%0d_ram_word", v), ram[tbl[v].addr], tbl[v].exp_wr != 0 ? clean_w : bad_w);
      if (tbl[v].exp_wr != 0) chk($sformatf("tbl%0d_wr_addr", v), last_wr_addr, tbl[v].addr);
      if (tbl[v].exp_db != 0) chk($sformatf("tbl%0d_dbit_addr", v), dbit_addr, tbl[v].addr);
    end

    // Randomized images checked against the nearest-codeword model
    for (int p = 0; p < 3; p++) begin
      clean_image();
      for (int a = 0; a < DEPTH; a++) begin
        kind = $urandom_range(0, 3);
        b0 = $urandom_range(0, WW - 1);
        b1 = (b0 + 1 + $urandom_range(0, WW - 2)) % WW;
        if (kind >= 2) img[a][b0] = ~img[a][b0];
        if (kind == 3) img[a][b1] = ~img[a][b1];
      end
      e_sb = 0; e_db = 0; e_wr = 0; last_db = -1;
      for (int a = 0; a < DEPTH; a++) begin
        kind = classify(img[a], bp);
        if (kind == 1) begin e_wr++; if (bp < 27) e_sb++; end
        if (kind == 2) begin e_db++; last_db = a; end
      end
      prep(1'b1);
      run_pass($urandom_range(0, 4));
      ram_err = 0;
      for (int a = 0; a < DEPTH; a++) begin
        kind = classify(img[a], bp);
        fdat = img[a];
        if (kind == 1) fdat[bp] = ~fdat[bp];
        if (ram[a] !== fdat) ram_err++;
      end
      chk($sformatf("rnd%0d_sbit_cnt", p), sbit_cnt, e_sb > CMAX ? CMAX : e_sb);
      chk($sformatf("rnd%0d_dbit_cnt", p), dbit_cnt, e_db > CMAX ? CMAX : e_db);
      chk($sformatf("rnd%0d_writes", p), n_wr, e_wr);
      chk($sformatf("rnd%0d_irq_cycles", p), n_irq, e_db);
      chk($sformatf("rnd%0d_ram_bad_words", p), ram_err, 0);
      chk($sformatf("rnd%0d_port_viol", p), n_viol, 0);
      if (last_db >= 0) chk($sformatf("rnd%0d_dbit_addr", p), dbit_addr, last_db);
    end

    // Functional write to the scrub address while the read is in flight
    clean_image();
    img[12][7] = ~img[12][7];
    r = $urandom;
    fdat = enc(r[26:0]);
    prep(1'b1);
    scrub_intv = '0;
    scrub_en = 1'b1;
    wait_read(6'd12, t);
    @(negedge clk);
    func_busy = 1'b1; func_we = 1'b1; func_waddr = 6'd12; func_wdata = fdat;
    @(negedge clk);
    func_busy = 1'b0; func_we = 1'b0;
    run_pass(0);
    chk("hazard_writes", n_wr, 0);
    chk("hazard_sbit_cnt", sbit_cnt, 1);
    chk("hazard_ram12", ram[12], fdat);

    // Saturation, then clear in the same cycle as a counted error
    clean_image();
    for (int a = 0; a < DEPTH; a++) begin
      b0 = $urandom_range(0, 26);
      img[a][b0] = ~img[a][b0];
    end
    prep(1'b1);
    run_pass(0);
    chk("sat_sbit_cnt", sbit_cnt, CMAX);
    chk("sat_writes", n_wr, DEPTH);
    clean_image();
    clean_w = img[3];
    img[3][11] = ~img[3][11];
    prep(1'b0);
    scrub_intv = '0;
    scrub_en = 1'b1;
    wait_read(6'd3, t);
    repeat (2) @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_beats_inc", sbit_cnt, 0);
    run_pass(0);
    chk("clr_writes", n_wr, 1);
    chk("clr_ram3", ram[3], clean_w);
    chk("clr_sbit_after", sbit_cnt, 0);

    // Port contention during RD, word latencies, then reset mid-operation
    clean_image();
    img[1][5] = ~img[1][5];
    prep(1'b1);
    func_busy = 1'b1;
    scrub_intv = '0;
    scrub_en = 1'b1;
    busy_req = 0;
    repeat (12) begin @(negedge clk); if (mem_req) busy_req++; end
    chk("busy_req_held", busy_req, 0);
    func_busy = 1'b0;
    #1;
    chk("busy_release_read", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 6'd0});
    wait_read(6'd1, t);
    chk("lat_clean_word", t, 5);
    wait_read(6'd2, t);
    chk("lat_corrected_word", t, 6);
    chk("busy_port_viol", n_viol, 0);
    chk("busy_sbit_cnt", sbit_cnt, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop_reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, sbit_cnt, dbit_cnt,
                                dbit_addr, dbit_irq, pass_done}, 64'd0);
    scrub_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_reset_idle", {mem_req, mem_addr}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
Background scrubber for the ECC-protected FIFO RAM. Each RAM word is 34 bits: {parity[6:0], data[26:0]}. The block walks every address in turn, reads the word and checks it through an instance of ecc_27_cal. On a single-bit error it writes the corrected word back. On a double-bit error it logs the failing address and raises an interrupt. It shares the single RAM port with the functional FIFO logic, which always has priority.

Parameters:
ADDR_WIDTH, 6, RAM address width; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 27, data field width.
PARITY_WIDTH, 7, parity field width.
CNT_WIDTH, 16, width of the error counters.
INTV_WIDTH, 16, width of the inter-word interval counter.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
scrub_en  in  1  enables scrubbing; sampled in IDLE and NEXT
scrub_intv  in  INTV_WIDTH  idle cycles between word scrubs
func_busy  in  1  functional logic owns the RAM port this cycle
func_we  in  1  functional write strobe
func_waddr  in  ADDR_WIDTH  functional write address
mem_req  out  1  scrubber RAM access request; valid only when func_busy=0
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  scrub address
mem_wdata  out  DATA_WIDTH+PARITY_WIDTH  corrected word {parity_out, data_out}
mem_rdata  in  DATA_WIDTH+PARITY_WIDTH  read data, valid exactly 1 cycle after a read request
sbit_cnt  out  CNT_WIDTH  corrected-error count, saturating
dbit_cnt  out  CNT_WIDTH  uncorrectable-error count, saturating
dbit_addr  out  ADDR_WIDTH  address of the most recent double-bit error
dbit_irq  out  1  1-cycle pulse on each double-bit error
pass_done  out  1  1-cycle pulse when the last address finishes
cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset: all outputs are 0. FSM enters IDLE. The address pointer and interval counter are 0.
- FSM states: IDLE, WAIT, RD, RD_WAIT, CHECK, WR, NEXT.
- IDLE: if scrub_en=1, load the interval counter with scrub_intv and go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, go to RD. scrub_intv=0 goes to RD on the next cycle.
- RD: drive mem_req=1 and mem_we=0 only when func_busy=0. If func_busy=1, hold RD and keep mem_req=0; there is no timeout. Once issued, go to RD_WAIT.
- RD_WAIT: capture mem_rdata into a register, then go to CHECK.
- CHECK:
  - Feed the registered word to ecc_27_cal with bypass=0.
  - sbit_err with a nonzero mask: increment sbit_cnt and go to WR.
  - sbit_err with a zero mask (parity-bit-only error): still go to WR, so the parity is regenerated.
  - dbit_err: increment dbit_cnt, load dbit_addr, pulse dbit_irq, no write, go to NEXT.
  - No error: go to NEXT.
- WR:
  - Hazard: if a functional write to the scrub address occurred (func_we=1 and func_waddr=mem_addr) at any cycle from RD issue through WR, set an abort flag. An abort skips the writeback and goes to NEXT; the counter increment stands.
  - Otherwise drive mem_req=1, mem_we=1 and mem_wdata={parity_out, data_out} when func_busy=0, holding while func_busy=1.
- NEXT:
  - Increment the address pointer, wrapping from 2**ADDR_WIDTH-1 to 0.
  - On wrap, pulse pass_done.
  - If scrub_en=1, reload the interval counter and go to WAIT; else go to IDLE.
- scrub_en=0 mid-operation: the current word always completes through NEXT, so there is no partial writeback.
- Counters:
  - Saturate at all-ones.
  - cnt_clr has priority over a same-cycle increment; the result is 0.
- Reset mid-operation: the FSM is forced to IDLE and any pending write is dropped. The RAM content remains valid because writes are single-cycle.
- mem_req is never 1 while func_busy=1.
- Latency: a clean word takes 3 cycles from RD issue to NEXT; a corrected word takes 4, with no contention.

Decomposition:
- Shared package (ecc_pkg):
  - scrub state encoding (3-bit enumerated constants).
  - DATA_WIDTH/PARITY_WIDTH defaults.
  - word-field slice constants (data [26:0], parity [33:27]).
- One sub-module: ecc_27_cal instantiated as u_ecc. Its parity_in/data_in come from the registered read word, and bypass is tied to 0. No other sub-modules.

Test Plan:
- Clean RAM, scrub_intv=0, depth 64 -> 64 reads, zero writes, counters 0, pass_done pulses after addr 63, pointer wraps to 0.
- Word at addr 5 with data bit 3 flipped -> one write to addr 5 with corrected data and original parity; sbit_cnt=1; dbit_irq stays 0.
- Word at addr 9 with data bits 0 and 1 flipped -> no write; dbit_cnt=1, dbit_addr=9, dbit_irq high for exactly 1 cycle.
- func_busy held high for 10 cycles during RD -> mem_req stays 0 for those 10 cycles, the read issues on the first cycle func_busy=0, and no cycle has mem_req and func_busy both high.
- Single-bit error at addr 12 plus func_we with func_waddr=12 during RD_WAIT -> writeback aborted, sbit_cnt=1, RAM holds the functional data.
- sbit_cnt preloaded to 0xFFFF by 65535 errors (or forced), then another error -> sbit_cnt stays 0xFFFF; cnt_clr plus a same-cycle error -> 0.
